iterst_sched: RTL
=================

# iterst_sched

Round-robin scheduler that time-multiplexes one iterated-state step datapath among N requesters. It keeps a private state word for each requester and grants at most one request per cycle. The granted request is stepped (out = in XOR st; st_next = in), and the result is returned through a single registered response port with backpressure. It sits between the per-channel producers and the shared ReWire-generated step device, so the one device can serve many independent streams.

## Interface
- NCH, 4, number of requester channels (2..16)
- DATA_W, 1, width of request data, state word and response data
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NCH  per-channel request valid
- req_data  in  NCH*DATA_W  per-channel request data; channel i occupies slice [i*DATA_W +: DATA_W]
- req_ready  out  NCH  per-channel accept strobe (one-hot or zero)
- resp_valid  out  1  response valid
- resp_data  out  DATA_W  stepped output (in XOR old state)
- resp_id  out  $clog2(NCH)  channel that produced the response
- resp_ready  in  1  downstream accepts the response
- step_count  out  16  accepted-step counter; present only with ITERST_SCHED_STATS_EN

## Operation
- State bank: NCH x DATA_W registers, st[i].
- Accept condition: can_accept = !resp_valid || resp_ready.
- Arbiter: round-robin over req_valid, starting at pointer ptr.
- grant is one-hot. req_ready = grant & {NCH{can_accept}}.
- On acceptance of channel g:
  - resp_data <= req_data[g] ^ st[g]
  - resp_id <= g
  - resp_valid <= 1
  - st[g] <= req_data[g]
  - ptr <= (g+1) mod NCH
- Without an acceptance:
  - ptr holds.
  - resp_valid clears if resp_ready is 1; otherwise the response holds stable.
- Requester rules: once req_valid is raised, it and req_data hold until req_ready. The scheduler does not check this.
- Response rules: resp_* are stable while resp_valid && !resp_ready.
- Fairness: a continuously requesting channel waits at most NCH-1 grants.
- Same channel back-to-back: the second step uses the state written by the first. No hazard, because the state write completes at the acceptance edge.
- Lone requester: it is granted every cycle that can_accept holds, even when ptr points at it or past it.
- No requests: no grant, ptr and state hold.
- All request bits are cleared in the grant logic when can_accept=0. No state changes while stalled.
- Reset values:
  - st[*]=0, ptr=0
  - resp_valid=0, resp_data=0, resp_id=0
  - step_count=0
  - req_ready=0 during reset
- Reset mid-operation: an in-flight response is discarded and all channel state returns to 0.

## Timing
- req_ready is combinational from req_valid, resp_valid, resp_ready and ptr. There is no combinational path from req_data.
- Latency: a request accepted in cycle T has resp_valid=1 in cycle T+1.
- Throughput: one step per cycle while resp_ready=1.
- With resp_ready held 0, after one acceptance all req_ready=0 until the response drains.
- Drain and accept in the same cycle are allowed; the new response replaces the old one at the edge.

## Configuration
- ITERST_SCHED_STATS_EN defined:
  - The step_count port and its counter exist.
  - The counter increments by 1 on every acceptance and saturates at 16'hFFFF.
  - It resets to 0.
- ITERST_SCHED_STATS_EN undefined: no port and no counter. All other behaviour is identical.

## Structure
- Package iterst_pkg holds:
  - localparam ITERST_CNT_W=16
  - function iterst_step(in, st), returning {out, st_next}
  - typedef iterst_resp_t {id, data}
- One sub-module, iterst_rr_arb:
  - parameter NCH
  - inputs req, ptr, en
  - outputs grant (one-hot) and grant_idx
  - purely combinational
- Top level holds the state bank, the response register, ptr and the optional counter.

## Test plan
- Reset then idle: all outputs 0 and req_ready=0 for 10 cycles. With STATS, step_count=0.
- NCH=4, DATA_W=1, channel 0 alone sends 1,1,0,0 with resp_ready=1: resp_data=1,0,1,0 on cycles T+1..T+4, resp_id=0, st[0] ends at 0.
- All four channels request continuously with data 1: grant order 0,1,2,3,0; first-round responses each 1, second-round response for channel 0 is 0.
- resp_ready=0 for 5 cycles with channels 1 and 2 requesting:
  - one acceptance (channel 1), then req_ready=0 and resp_* stable
  - after resp_ready rises, channel 2 is accepted in the same cycle the channel-1 response drains
- Assert rst while resp_valid=1 and st[3]=1: resp_valid drops immediately. After release, channel 3 data 1 gives resp_data=1, proving the state was cleared.
- STATS build: 70000 accepted steps give step_count=16'hFFFF, saturated, no wrap.

Source files
------------

// File: rtl/iterst_pkg.sv
// Shared types and the step function for the iterated-state scheduler.
package iterst_pkg;

  localparam int unsigned ITERST_CNT_W    = 16;
  // Widest data word and channel id the scheduler can carry.
  localparam int unsigned ITERST_MAX_W    = 32;
  localparam int unsigned ITERST_ID_MAX_W = 4;

  // Registered response payload, sized for the widest configuration.
  typedef struct packed {
    logic [ITERST_ID_MAX_W-1:0] id;
    logic [ITERST_MAX_W-1:0]    data;
  } iterst_resp_t;

  // One step of the iterated-state device: returns {out, st_next}.
  function automatic logic [2*ITERST_MAX_W-1:0] iterst_step(
    input logic [ITERST_MAX_W-1:0] din,
    input logic [ITERST_MAX_W-1:0] st
  );
    return {din ^ st, din};
  endfunction

endpackage

// File: rtl/iterst_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module iterst_rr_arb #(
  parameter int unsigned NCH = 4,
  localparam int unsigned IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [NCH-1:0] grant,
  output logic [IDW-1:0] grant_idx
);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan channels ptr, ptr+1, ... (mod NCH) and grant the first one requesting.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NCH)) begin
        sum = sum - (IDW+1)'(NCH);
      end
      idx = sum[IDW-1:0];
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iterst_sched.sv
// Round-robin scheduler sharing one iterated-state step datapath among NCH
// requesters, each with its own state word, behind a registered response port.
// Optional accepted-step counter enabled by defining ITERST_SCHED_STATS_EN.
// DATA_W up to 32, NCH 2..16.
module iterst_sched
  import iterst_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DATA_W = 1,
  localparam int unsigned IDW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DATA_W-1:0]   req_data,
  output logic [NCH-1:0]          req_ready,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic [IDW-1:0]          resp_id,
  input  logic                    resp_ready
`ifdef ITERST_SCHED_STATS_EN
  ,
  output logic [ITERST_CNT_W-1:0] step_count
`endif
);

  logic                      can_accept;
  logic                      accept;
  logic [NCH-1:0]            grant;
  logic [IDW-1:0]            grant_idx;
  logic [DATA_W-1:0]         sel_data;
  logic [DATA_W-1:0]         sel_st;
  logic [2*ITERST_MAX_W-1:0] step;
  logic [IDW:0]              ptr_inc;

  logic [DATA_W-1:0] st_q [NCH];
  logic [DATA_W-1:0] st_d [NCH];
  iterst_resp_t      resp_q, resp_d;
  logic              resp_valid_q, resp_valid_d;
  logic [IDW-1:0]    ptr_q, ptr_d;

  // A new response may be loaded when the register is empty or draining now.
  assign can_accept = !resp_valid_q || resp_ready;

  iterst_rr_arb #(.NCH(NCH)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (can_accept && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Select the granted channel's data and state word (one-hot AND-OR mux).
  always_comb begin
    sel_data = '0;
    sel_st   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
        sel_st   = sel_st | st_q[i];
      end
    end
  end

  assign step = iterst_step(ITERST_MAX_W'(sel_data), ITERST_MAX_W'(sel_st));

  // Pointer moves to the channel after the one just granted.
  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (IDW+1)'(1);
    if (ptr_inc >= (IDW+1)'(NCH)) begin
      ptr_inc = '0;
    end
  end

  // Next state for the state bank, response register and pointer.
  always_comb begin
    st_d         = st_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    ptr_d        = ptr_q;
    if (accept) begin
      resp_d.data  = step[2*ITERST_MAX_W-1:ITERST_MAX_W];
      resp_d.id    = ITERST_ID_MAX_W'(grant_idx);
      resp_valid_d = 1'b1;
      ptr_d        = ptr_inc[IDW-1:0];
      for (int unsigned i = 0; i < NCH; i++) begin
        if (grant[i]) begin
          st_d[i] = step[DATA_W-1:0];
        end
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State register; reset discards any in-flight response and clears all state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i] <= '0;
      end
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      st_q         <= st_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_q.data[DATA_W-1:0];
  assign resp_id    = resp_q.id[IDW-1:0];

  // Payload bits beyond the configured widths are carried but never read.
  logic unused_bits;
  assign unused_bits = ^{resp_q, step};

`ifdef ITERST_SCHED_STATS_EN
  logic [ITERST_CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of accepted steps.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + ITERST_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_count = cnt_q;
`endif

endmodule
